// File: rtl/lsu_bus_master.sv
// Load/store unit bus initiator: turns core byte/half/word requests into one or two
// word-aligned bus transactions with byte enables, and returns extended load data.
module lsu_bus_master #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  mem_valid_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_we_o,
  input  logic                  mem_ready_i,
  input  logic [31:0]           mem_rdata_i,
  output logic [2:0]            state_dbg
);

  // Handshakes: a request transfers on a rising edge where req_valid_i && req_ready_o;
  // each mem_valid_o pulse is answered by exactly one mem_ready_i cycle, sampled only in WAIT0/WAIT1.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t state, state_next;

  logic                  we_q, uns_q, split_q;
  logic [1:0]            size_q, off_q;
  logic [7:0]            mask_q;
  logic [31:0]           whi_q, lo_q;
  logic [ADDR_WIDTH-1:0] base_q;

  logic [7:0]            size_mask, req_mask;
  logic                  req_split;
  logic [63:0]           req_wide;
  logic [ADDR_WIDTH-1:0] req_base;

  logic [31:0]           lo_src, hi_src, raw, ext;
  logic                  capture, lo_en;

  logic                  mem_valid_n, resp_valid_n, resp_err_n;
  logic [3:0]            mem_we_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic [31:0]           mem_wdata_n, resp_rdata_n;

  assign req_ready_o = (state == IDLE);
  assign state_dbg   = state;

  // An access splits exactly when its byte mask spills into the next word.
  always_comb begin
    case (req_size_i)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      default: size_mask = 8'h0F;
    endcase
    req_mask  = size_mask << req_addr_i[1:0];
    req_split = (req_mask[7:4] != 4'h0);
    req_wide  = {32'h0, req_wdata_i} << {req_addr_i[1:0], 3'b000};
    req_base  = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
  end

  // Load data path sees the incoming word directly on the cycle it completes the access.
  always_comb begin
    lo_src = (state == WAIT0) ? mem_rdata_i : lo_q;
    hi_src = (state == WAIT1) ? mem_rdata_i : 32'h0;
    raw    = 32'({hi_src, lo_src} >> {off_q, 3'b000});
    case (size_q)
      2'b00:   ext = uns_q ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   ext = uns_q ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_comb begin
    state_next   = state;
    capture      = 1'b0;
    lo_en        = 1'b0;
    mem_valid_n  = 1'b0;
    mem_we_n     = 4'h0;
    mem_addr_n   = mem_addr_o;
    mem_wdata_n  = mem_wdata_o;
    resp_valid_n = 1'b0;
    resp_err_n   = 1'b0;
    resp_rdata_n = 32'h0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          capture = 1'b1;
          if (req_size_i == 2'b11) begin
            state_next   = RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
          end else begin
            state_next  = REQ0;
            mem_valid_n = 1'b1;
            mem_addr_n  = req_base;
            mem_we_n    = req_we_i ? req_mask[3:0] : 4'h0;
            mem_wdata_n = req_wide[31:0];
          end
        end
      end
      REQ0: state_next = WAIT0;
      WAIT0: begin
        if (mem_ready_i) begin
          lo_en = 1'b1;
          if (split_q) begin
            state_next  = REQ1;
            mem_valid_n = 1'b1;
            mem_addr_n  = base_q + ADDR_WIDTH'(4);
            mem_we_n    = we_q ? mask_q[7:4] : 4'h0;
            mem_wdata_n = whi_q;
          end else begin
            state_next   = RESP;
            resp_valid_n = 1'b1;
            resp_rdata_n = we_q ? 32'h0 : ext;
          end
        end
      end
      REQ1: state_next = WAIT1;
      WAIT1: begin
        if (mem_ready_i) begin
          state_next   = RESP;
          resp_valid_n = 1'b1;
          resp_rdata_n = we_q ? 32'h0 : ext;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mem_valid_o  <= 1'b0;
      mem_we_o     <= 4'h0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= 32'h0;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= 32'h0;
    end else begin
      state        <= state_next;
      mem_valid_o  <= mem_valid_n;
      mem_we_o     <= mem_we_n;
      mem_addr_o   <= mem_addr_n;
      mem_wdata_o  <= mem_wdata_n;
      resp_valid_o <= resp_valid_n;
      resp_err_o   <= resp_err_n;
      resp_rdata_o <= resp_rdata_n;
    end
  end

  // Request context needs no reset: it is always rewritten before being used.
  always_ff @(posedge clk) begin
    if (capture) begin
      we_q    <= req_we_i;
      uns_q   <= req_unsigned_i;
      size_q  <= req_size_i;
      off_q   <= req_addr_i[1:0];
      split_q <= req_split;
      mask_q  <= req_mask;
      whi_q   <= req_wide[63:32];
      base_q  <= req_base;
    end
    if (lo_en) lo_q <= mem_rdata_i;
  end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store unit initiator that turns core load/store requests into word-granular transactions on the valid/ready/byte-enable memory port served by the dual-port RAM.
- Generates byte enables and write-data lane shifting, and extracts plus sign/zero-extends read data.
- Splits any access that crosses a 32-bit word boundary into two bus transactions.
- Sits between the execute stage and RAM port B.

Parameters:
ADDR_WIDTH, 32, width of byte address on request and bus sides (matches RISCV_ADDR_WIDTH)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid_i  input  1  core request present
req_ready_o  output  1  LSU can accept a request this cycle
req_we_i  input  1  1=store, 0=load
req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0
req_addr_i  input  ADDR_WIDTH  byte address, any alignment
req_wdata_i  input  32  store data, right-aligned
resp_valid_o  output  1  one-cycle pulse: request complete
resp_rdata_o  output  32  extended load data, 0 for stores
resp_err_o  output  1  qualifies resp_valid_o: illegal size
mem_valid_o  output  1  bus request strobe
mem_addr_o  output  ADDR_WIDTH  word-aligned byte address (bits[1:0]=00)
mem_wdata_o  output  32  lane-shifted write data
mem_we_o  output  4  byte enables, 0000 for loads
mem_ready_i  input  1  bus response, one cycle per issued strobe
mem_rdata_i  input  32  read word, valid with mem_ready_i

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high.
- Reset values: mem_valid_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, state=IDLE. req_ready_o=1 after reset (combinational: state==IDLE).
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP. All outputs are registered except req_ready_o.
- IDLE:
  - On req_valid_i&req_ready_o, capture the request.
  - size 11: go to RESP with resp_err_o=1; no bus access.
  - Otherwise compute off=addr[1:0] and n=1/2/4 bytes; split = off+n>4.
  - mask8 = ((1<<n)-1)<<off; wide = {32'b0,wdata}<<(8*off).
  - Go to REQ0.
- REQ0 (one cycle): mem_valid_o=1, mem_addr_o=addr&~3, mem_we_o=store?mask8[3:0]:0, mem_wdata_o=wide[31:0]. Next state WAIT0.
- mem_valid_o is high for exactly one cycle per transaction; it is never held across cycles.
- WAIT0: mem_valid_o=0. On mem_ready_i, latch rdata into lo, then go to REQ1 if split, else RESP. Wait indefinitely otherwise; no timeout.
- REQ1: as REQ0 with mem_addr_o=(addr&~3)+4 (wraps modulo 2^ADDR_WIDTH), mem_we_o=store?mask8[7:4]:0, mem_wdata_o=wide[63:32]. Next state WAIT1.
- WAIT1: on mem_ready_i, latch hi, go to RESP.
- RESP (one cycle):
  - resp_valid_o=1.
  - Load: raw={hi,lo}>>(8*off), where hi=0 if not split; take n bytes, then zero- or sign-extend from bit 8n-1.
  - Store: resp_rdata_o=0.
  - resp_err_o=0 except for illegal size.
  - Next state IDLE; a new request may be accepted in this same cycle's following IDLE cycle, not in RESP.
- Latency: aligned access accepted at edge E0: mem_valid_o high after E0, RAM ready after E1, resp_valid_o high after E2 (3 cycles accept-to-response). Split access: 5 cycles. Illegal: resp_valid_o in cycle after E0.
- Handshakes:
  - mem_ready_i in IDLE, REQ0, REQ1 or RESP is ignored.
  - req_valid_i outside IDLE is ignored; the core must hold it until req_ready_o.
- Reset mid-operation: the FSM returns to IDLE at the reset edge and mem_valid_o drops. A later mem_ready_i from the abandoned access is ignored, and no resp_valid_o is produced for the aborted request.
- Store-after-load ordering: one outstanding request at a time, so ordering is trivially preserved.

Test Plan:
- RAM word 0x100=0x8877_6655; load byte signed addr 0x103 -> one bus access addr 0x100 we=0000; resp_rdata_o=0xFFFF_FF88 three cycles after accept.
- Same word; load half unsigned addr 0x102 -> resp_rdata_o=0x0000_8877; signed -> 0xFFFF_8877.
- Store word 0xAABB_CCDD to 0x101 -> two accesses: addr 0x100 we=1110 wdata=0xBBCC_DD00, then addr 0x104 we=0001 wdata=0x0000_00AA; readback word load 0x101 -> 0xAABB_CCDD, resp at cycle 5.
- Load half at 0xFFFF_FFFF -> second access at addr 0x0000_0000 (wrap); result {mem[0][7:0], mem[0xFFFF_FFFC][31:24]}.
- req_size_i=11 -> no mem_valid_o, resp_valid_o with resp_err_o=1 one cycle after accept; next request accepted normally.
- Assert reset while in WAIT0, then pulse mem_ready_i -> no resp_valid_o, outputs at reset values, req_ready_o=1.
